// File: rtl/keypad_entry_if.sv
// keypad_entry_if
//   Bundles the two handshakes around keypad_entry_ctrl:
//     - scanner side : key_in / key_ready in, key_ack out
//     - display side : entry_value / entry_digits / entry_overflow out
//     - operand side : value_out / value_valid / fifo_level out, value_ack in
//   slave  modport : the entry controller
//   master modport : whoever drives keys and pops operands (scanner + datapath / bench)
//   DIGITS and DEPTH must match the controller instance.
interface keypad_entry_if #(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 4
);
  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DIGITS + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    key_in;
  logic          key_ready;
  logic          key_ack;
  logic [W-1:0]  entry_value;
  logic [DW-1:0] entry_digits;
  logic          entry_overflow;
  logic [W-1:0]  value_out;
  logic          value_valid;
  logic          value_ack;
  logic [CW-1:0] fifo_level;

  modport slave (
    input  key_in, key_ready, value_ack,
    output key_ack, entry_value, entry_digits, entry_overflow,
           value_out, value_valid, fifo_level
  );

  modport master (
    output key_in, key_ready, value_ack,
    input  key_ack, entry_value, entry_digits, entry_overflow,
           value_out, value_valid, fifo_level
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Sits at the far end of the keypad scanner handshake. Each accepted key is
//   one of:
//     0-C (and D unless backspace is enabled) : append a hex digit
//     E                                       : clear the entry
//     F                                       : push the entry as an operand
//   Entered operands are queued in a DEPTH-deep FIFO popped via value_valid /
//   value_ack.
//
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   kif      : keypad_entry_if.slave (key handshake, live entry, operand FIFO)
//
// Parameters
//   DIGITS : max hex digits per operand (>= 2), operand width W = 4*DIGITS
//   DEPTH  : operand FIFO depth, power of two, >= 2
//
// Build option
//   KEYPAD_ENTRY_BACKSPACE_EN : when defined, key D deletes the last digit
//                               instead of being entered as digit 0xD.
module keypad_entry_ctrl #(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_if.slave kif
);
  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DIGITS + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
  localparam logic [3:0] KEY_BS  = 4'hD;
`endif

  typedef enum logic {S_IDLE, S_ACK} state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic [W-1:0]              val_q, val_d;
  logic [DW-1:0]             dig_q, dig_d;
  logic                      ovf_q, ovf_d;

  logic [DEPTH-1:0][W-1:0]   mem_q;
  logic [PW-1:0]             wptr_q, wptr_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------------
  logic is_clr, is_ent, is_bs, is_dig;
  logic has_digits, entry_full;
  logic fifo_full, fifo_empty;
  logic stall, accept, push, pop;

  always_comb begin
    is_clr = (kif.key_in == KEY_CLR);
    is_ent = (kif.key_in == KEY_ENT);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    is_bs  = (kif.key_in == KEY_BS);
`else
    is_bs  = 1'b0;
`endif
    is_dig = !is_clr && !is_ent && !is_bs;
  end

  assign has_digits = (dig_q != '0);
  assign entry_full = (dig_q >= DW'(DIGITS));
  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Only a non-empty enter can need FIFO space; it uses the pre-edge level, so
  // a pop on the same edge frees the slot but the enter waits one more clock.
  assign stall  = is_ent && has_digits && fifo_full;
  assign accept = (state_q == S_IDLE) && kif.key_ready && !stall;
  assign pop    = !fifo_empty && kif.value_ack;

  // ---------------------------------------------------------------------------
  // Handshake FSM and entry accumulator
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    val_d   = val_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    push    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (is_clr) begin
            val_d = '0;
            dig_d = '0;
            ovf_d = 1'b0;
          end else if (is_ent) begin
            // Enter with an empty entry is acked but otherwise a no-op.
            if (has_digits) begin
              push  = 1'b1;
              val_d = '0;
              dig_d = '0;
              ovf_d = 1'b0;
            end
          end else if (is_bs) begin
            if (has_digits) begin
              val_d = val_q >> 4;
              dig_d = dig_q - DW'(1);
              ovf_d = 1'b0;
            end
          end else if (is_dig) begin
            if (!entry_full) begin
              val_d = {val_q[W-5:0], kif.key_in};
              dig_d = dig_q + DW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      S_ACK: begin
        // Hold ack until the scanner drops ready so one ready pulse is
        // exactly one key.
        if (!kif.key_ready) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand FIFO pointers / level
  // ---------------------------------------------------------------------------
  always_comb begin
    // Power-of-two depth lets the pointers wrap by plain overflow.
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      val_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      val_q   <= val_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: value_out is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= val_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign kif.key_ack        = ack_q;
  assign kif.entry_value    = val_q;
  assign kif.entry_digits   = dig_q;
  assign kif.entry_overflow = ovf_q;
  assign kif.value_valid    = !fifo_empty;
  assign kif.value_out      = fifo_empty ? '0 : mem_q[rptr_q];
  assign kif.fifo_level     = cnt_q;

endmodule
